// File: rtl/out_alu_control_unit_pkg.sv
// rtl/out_alu_control_unit_pkg.sv - shared op codes, FIFO_OUT field positions and arbiter state type
package out_alu_control_unit_pkg;

    // Op codes carried in the low field of every FIFO word.
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // Field positions are shared with the FIFO_IN ctrl word so CSR decode is common.
    localparam int unsigned OP_BIT  = 0;
    localparam int unsigned ID_BIT  = 2;
    localparam int unsigned RES_BIT = 10;

    // Round-robin pointer: which channel wins when both hold a result.
    typedef enum logic {
        RR_ADD = 1'b0,
        RR_MUL = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/d_ff_async_en.sv
// rtl/d_ff_async_en.sv - enabled register with clear, the library flop the hold registers build on
// Ports: clk, rst (clears q at the clock edge), en (load d), d, q.
module d_ff_async_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // The clear is sampled on the clock edge in this block so the whole
    // result path shares one synchronous reset domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/out_res_hold_reg.sv
// rtl/out_res_hold_reg.sv - one-entry holding register for a single ALU result channel
// Ports: clk, rst; valid/result/id from the ALU; ready back to the ALU (registered);
//        clear from the arbiter; hold_vld/hold_result/hold_id toward the pack mux.
module out_res_hold_reg #(
    parameter int DATA_SIZE = 16,
    parameter int ID_SIZE   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_SIZE-1:0] result,
    input  logic [ID_SIZE-1:0]   id,
    input  logic                 clear,
    output logic                 ready,
    output logic                 hold_vld,
    output logic [DATA_SIZE-1:0] hold_result,
    output logic [ID_SIZE-1:0]   hold_id
);

    logic                         capture;
    logic [DATA_SIZE+ID_SIZE-1:0] hold_data;

    // Capture only into an empty slot and clear only a full one, so both
    // can never hit the same cycle; a valid against a full slot is ignored.
    assign capture = valid & ~hold_vld;
    assign ready   = ~hold_vld;

    d_ff_async_en #(.WIDTH(1)) u_vld (
        .clk (clk),
        .rst (rst),
        .en  (capture | clear),
        .d   (capture),
        .q   (hold_vld)
    );

    d_ff_async_en #(.WIDTH(DATA_SIZE + ID_SIZE)) u_data (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   ({result, id}),
        .q   (hold_data)
    );

    assign hold_result = hold_data[DATA_SIZE+ID_SIZE-1:ID_SIZE];
    assign hold_id     = hold_data[ID_SIZE-1:0];

endmodule

// File: rtl/out_alu_control_unit.sv
// rtl/out_alu_control_unit.sv - collects adder/multiplier results and writes them round-robin into FIFO_OUT
// Ports: clk, rst; a_* adder result handshake; m_* multiplier result handshake;
//        full_out/w_en_out/fifo_out_data toward FIFO_OUT; add_cnt/mul_cnt result
//        counters for CSR readback; busy when any result is still held.
module out_alu_control_unit
    import out_alu_control_unit_pkg::*;
#(
    parameter int DATA_SIZE      = 16,
    parameter int ID_SIZE        = 8,
    parameter int OPERATION_SIZE = 2,
    parameter int CNT_SIZE       = 16,
    parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid_res,
    input  logic [DATA_SIZE-1:0]      a_result,
    input  logic [ID_SIZE-1:0]        a_id_res,
    output logic                      a_ready_res,
    input  logic                      m_valid_res,
    input  logic [DATA_SIZE-1:0]      m_result,
    input  logic [ID_SIZE-1:0]        m_id_res,
    output logic                      m_ready_res,
    input  logic                      full_out,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
    output logic [CNT_SIZE-1:0]       add_cnt,
    output logic [CNT_SIZE-1:0]       mul_cnt,
    output logic                      busy
);

    logic                 a_hold_vld;
    logic [DATA_SIZE-1:0] a_hold_res;
    logic [ID_SIZE-1:0]   a_hold_id;
    logic                 m_hold_vld;
    logic [DATA_SIZE-1:0] m_hold_res;
    logic [ID_SIZE-1:0]   m_hold_id;

    logic                 grant_a;
    logic                 grant_m;
    rr_sel_e              rr_ptr;
    rr_sel_e              rr_ptr_next;
    logic [CNT_SIZE-1:0]  add_cnt_r;
    logic [CNT_SIZE-1:0]  mul_cnt_r;

    out_res_hold_reg #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_hold_add (
        .clk         (clk),
        .rst         (rst),
        .valid       (a_valid_res),
        .result      (a_result),
        .id          (a_id_res),
        .clear       (grant_a),
        .ready       (a_ready_res),
        .hold_vld    (a_hold_vld),
        .hold_result (a_hold_res),
        .hold_id     (a_hold_id)
    );

    out_res_hold_reg #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_hold_mul (
        .clk         (clk),
        .rst         (rst),
        .valid       (m_valid_res),
        .result      (m_result),
        .id          (m_id_res),
        .clear       (grant_m),
        .ready       (m_ready_res),
        .hold_vld    (m_hold_vld),
        .hold_result (m_hold_res),
        .hold_id     (m_hold_id)
    );

    // Grant is combinational from registered hold state; full_out and rst veto it
    // in the same cycle. The pointer always moves to the channel that lost or
    // did not request, so a lone request still hands priority over.
    always_comb begin
        grant_a     = 1'b0;
        grant_m     = 1'b0;
        rr_ptr_next = rr_ptr;
        if (!rst && !full_out) begin
            if (a_hold_vld && (!m_hold_vld || rr_ptr == RR_ADD)) begin
                grant_a     = 1'b1;
                rr_ptr_next = RR_MUL;
            end else if (m_hold_vld) begin
                grant_m     = 1'b1;
                rr_ptr_next = RR_ADD;
            end
        end
    end

    assign w_en_out = grant_a | grant_m;

    // Idle cycles drive zero so the word is clean during and after reset.
    always_comb begin
        fifo_out_data = '0;
        if (grant_a) begin
            fifo_out_data[OP_BIT  +: OPERATION_SIZE] = OP_ADD;
            fifo_out_data[ID_BIT  +: ID_SIZE]        = a_hold_id;
            fifo_out_data[RES_BIT +: DATA_SIZE]      = a_hold_res;
        end else if (grant_m) begin
            fifo_out_data[OP_BIT  +: OPERATION_SIZE] = OP_MUL;
            fifo_out_data[ID_BIT  +: ID_SIZE]        = m_hold_id;
            fifo_out_data[RES_BIT +: DATA_SIZE]      = m_hold_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= RR_ADD;
            add_cnt_r <= '0;
            mul_cnt_r <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            if (grant_a) begin
                add_cnt_r <= add_cnt_r + 1'b1;
            end
            if (grant_m) begin
                mul_cnt_r <= mul_cnt_r + 1'b1;
            end
        end
    end

    assign add_cnt = add_cnt_r;
    assign mul_cnt = mul_cnt_r;
    assign busy    = a_hold_vld | m_hold_vld;

endmodule

// File: tb/tb_out_alu_control_unit.sv
// tb/tb_out_alu_control_unit.sv - scoreboard bench for out_alu_control_unit
module tb_out_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid_res;
    logic [15:0] a_result;
    logic [7:0]  a_id_res;
    logic        a_ready_res;
    logic        m_valid_res;
    logic [15:0] m_result;
    logic [7:0]  m_id_res;
    logic        m_ready_res;
    logic        full_out;
    logic        w_en_out;
    logic [25:0] fifo_out_data;
    logic [15:0] add_cnt;
    logic [15:0] mul_cnt;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [25:0] exp_q[$];
    logic [25:0] mon_exp;
    int          ai;
    int          mi;
    logic        a_take;
    logic        m_take;

    always #5 clk = ~clk;

    out_alu_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid_res   (a_valid_res),
        .a_result      (a_result),
        .a_id_res      (a_id_res),
        .a_ready_res   (a_ready_res),
        .m_valid_res   (m_valid_res),
        .m_result      (m_result),
        .m_id_res      (m_id_res),
        .m_ready_res   (m_ready_res),
        .full_out      (full_out),
        .w_en_out      (w_en_out),
        .fifo_out_data (fifo_out_data),
        .add_cnt       (add_cnt),
        .mul_cnt       (mul_cnt),
        .busy          (busy)
    );

    function automatic logic [25:0] pack(input logic [15:0] r, input logic [7:0] id,
                                         input logic [1:0] op);
        return {r, id, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (w_en_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h expected no write", fifo_out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_out_data", {6'd0, fifo_out_data}, {6'd0, mon_exp});
            end
        end
    end

    initial begin
        rst = 1'b1; full_out = 1'b0;
        a_valid_res = 1'b0; a_result = '0; a_id_res = '0;
        m_valid_res = 1'b0; m_result = '0; m_id_res = '0;
        tick(); tick();
        check("rst_a_ready", {31'd0, a_ready_res}, 1);
        check("rst_m_ready", {31'd0, m_ready_res}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;

        // Load both channels behind a full FIFO, then reset.
        full_out = 1'b1;
        a_valid_res = 1'b1; a_result = 16'h0BAD; a_id_res = 8'h01;
        m_valid_res = 1'b1; m_result = 16'hF00D; m_id_res = 8'h02;
        tick();
        a_valid_res = 1'b0; m_valid_res = 1'b0;
        check("load_busy", {31'd0, busy}, 1);
        check("load_a_ready", {31'd0, a_ready_res}, 0);
        check("load_m_ready", {31'd0, m_ready_res}, 0);
        rst = 1'b1;
        tick();
        check("rst2_busy", {31'd0, busy}, 0);
        check("rst2_a_ready", {31'd0, a_ready_res}, 1);
        check("rst2_m_ready", {31'd0, m_ready_res}, 1);
        check("rst2_w_en", {31'd0, w_en_out}, 0);
        check("rst2_data", {6'd0, fifo_out_data}, 0);
        check("rst2_add_cnt", {16'd0, add_cnt}, 0);
        check("rst2_mul_cnt", {16'd0, mul_cnt}, 0);
        rst = 1'b0; full_out = 1'b0;
        tick(); tick();
        check("post_rst_busy", {31'd0, busy}, 0);

        // Single ADD.
        a_valid_res = 1'b1; a_result = 16'h1234; a_id_res = 8'h05;
        exp_q.push_back(26'h048D015);
        tick();
        a_valid_res = 1'b0;
        check("add_ready_low", {31'd0, a_ready_res}, 0);
        check("add_w_en", {31'd0, w_en_out}, 1);
        tick();
        check("add_ready_back", {31'd0, a_ready_res}, 1);
        check("add_cnt_1", {16'd0, add_cnt}, 1);
        check("add_w_en_off", {31'd0, w_en_out}, 0);

        // Simultaneous results right after reset: ADD first, then MUL.
        rst = 1'b1; tick(); rst = 1'b0;
        a_valid_res = 1'b1; a_result = 16'h0001; a_id_res = 8'h01;
        m_valid_res = 1'b1; m_result = 16'h0F0F; m_id_res = 8'h02;
        exp_q.push_back(26'h0000405);
        exp_q.push_back(26'h03C3C0A);
        tick();
        a_valid_res = 1'b0; m_valid_res = 1'b0;
        check("sim_w_en_1", {31'd0, w_en_out}, 1);
        tick();
        check("sim_w_en_2", {31'd0, w_en_out}, 1);
        check("sim_a_ready", {31'd0, a_ready_res}, 1);
        check("sim_m_ready", {31'd0, m_ready_res}, 0);
        tick();
        check("sim_add_cnt", {16'd0, add_cnt}, 1);
        check("sim_mul_cnt", {16'd0, mul_cnt}, 1);
        check("sim_busy", {31'd0, busy}, 0);

        // Back-pressure: hold both for 5 cycles, extra valids ignored.
        full_out = 1'b1;
        a_valid_res = 1'b1; a_result = 16'hAAAA; a_id_res = 8'h10;
        m_valid_res = 1'b1; m_result = 16'h5555; m_id_res = 8'h20;
        tick();
        a_result = 16'hDEAD; a_id_res = 8'hEE;
        m_result = 16'hBEEF; m_id_res = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_a_ready", {31'd0, a_ready_res}, 0);
            check("bp_m_ready", {31'd0, m_ready_res}, 0);
            check("bp_w_en", {31'd0, w_en_out}, 0);
            tick();
        end
        full_out = 1'b0; a_valid_res = 1'b0; m_valid_res = 1'b0;
        exp_q.push_back(26'h2AAA841);
        exp_q.push_back(26'h1555482);
        #1;
        check("bp_drain_1", {31'd0, w_en_out}, 1);
        tick();
        check("bp_drain_2", {31'd0, w_en_out}, 1);
        tick();
        check("bp_drain_done", {31'd0, w_en_out}, 0);
        check("bp_add_cnt", {16'd0, add_cnt}, 2);
        check("bp_mul_cnt", {16'd0, mul_cnt}, 2);

        // Fairness: both channels streaming, writes must alternate.
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(pack(16'(16'h1000 + i), 8'(8'h40 + i), 2'b01));
            exp_q.push_back(pack(16'(16'h2000 + i), 8'(8'h80 + i), 2'b10));
        end
        ai = 0; mi = 0;
        for (int cyc = 0; cyc < 60 && (ai < 10 || mi < 10); cyc++) begin
            a_valid_res = (ai < 10);
            a_result = 16'(16'h1000 + ai); a_id_res = 8'(8'h40 + ai);
            m_valid_res = (mi < 10);
            m_result = 16'(16'h2000 + mi); m_id_res = 8'(8'h80 + mi);
            a_take = a_valid_res & a_ready_res;
            m_take = m_valid_res & m_ready_res;
            tick();
            if (a_take) ai++;
            if (m_take) mi++;
        end
        a_valid_res = 1'b0; m_valid_res = 1'b0;
        check("fair_a_accepted", ai, 10);
        check("fair_m_accepted", mi, 10);
        tick(); tick(); tick();
        check("fair_add_cnt", {16'd0, add_cnt}, 12);
        check("fair_mul_cnt", {16'd0, mul_cnt}, 12);
        check("fair_queue_empty", exp_q.size(), 0);

        // Counter wrap.
        force dut.add_cnt_r = 16'hFFFF;
        #1;
        release dut.add_cnt_r;
        check("wrap_preload", {16'd0, add_cnt}, 16'hFFFF);
        a_valid_res = 1'b1; a_result = 16'h0003; a_id_res = 8'h07;
        exp_q.push_back(26'h0000C1D);
        tick();
        a_valid_res = 1'b0;
        tick();
        check("wrap_add_cnt", {16'd0, add_cnt}, 0);

        // Mid-operation reset discards a held MUL result.
        full_out = 1'b1;
        m_valid_res = 1'b1; m_result = 16'h7777; m_id_res = 8'h33;
        tick();
        m_valid_res = 1'b0;
        check("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; full_out = 1'b0;
        tick(); tick();
        check("mid_busy_after", {31'd0, busy}, 0);
        check("mid_mul_cnt", {16'd0, mul_cnt}, 0);
        check("mid_m_ready", {31'd0, m_ready_res}, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
